// File: rtl/alu_pkg.sv
// Shared opcode and sequencer state definitions for the nibble-serial ALU front end.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // ADD and SUB chain a carry/borrow between nibbles; the logic ops do not.
    function automatic logic op_is_arith(input logic [1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_4bit.sv
// Combinational 4-bit ALU slice: add/sub with carry-in, bitwise and/or.
module alu_4bit
    import alu_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic [1:0] i_op,
    input  logic       i_cin,
    output logic [3:0] o_result,
    output logic       o_cout
);

    logic [4:0] w_sum;
    logic [4:0] w_diff;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_cin};
    // Bit 4 of the 5-bit difference goes high exactly when a < b + cin (borrow out).
    assign w_diff = {1'b0, i_a} - {1'b0, i_b} - {4'b0000, i_cin};

    always_comb begin
        o_result = 4'h0;
        o_cout   = 1'b0;
        case (i_op)
            OP_ADD: begin
                o_result = w_sum[3:0];
                o_cout   = w_sum[4];
            end
            OP_SUB: begin
                o_result = w_diff[3:0];
                o_cout   = w_diff[4];
            end
            OP_AND:  o_result = i_a & i_b;
            OP_OR:   o_result = i_a | i_b;
            default: o_result = 4'h0;
        endcase
    end

endmodule

// File: rtl/alu_nibble_serial.sv
// Wide-operand sequencer: streams one WIDTH-bit operation through a single alu_4bit,
// LSB nibble first, and returns the assembled result over a valid/ready response port.
module alu_nibble_serial
    import alu_pkg::*;
#(
    parameter int NIBBLES = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] in_a,
    input  logic [4*NIBBLES-1:0] in_b,
    input  logic [1:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_result,
    output logic                 out_cout,
    output logic                 out_zero,
    output state_t               o_dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // in_ready is high only in IDLE; out_valid only in DONE, holding all response
    // outputs steady until out_ready is seen.
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_t                    r_state;
    logic [NIBBLES-1:0][3:0]   r_a;
    logic [NIBBLES-1:0][3:0]   r_b;
    logic [NIBBLES-1:0][3:0]   r_result;
    logic [1:0]                r_op;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_carry;
    logic                      r_in_ready;
    logic                      r_out_valid;
    logic                      r_cout;
    logic                      r_zero;

    logic [3:0]                w_alu_a;
    logic [3:0]                w_alu_b;
    logic                      w_alu_cin;
    logic [3:0]                w_alu_result;
    logic                      w_alu_cout;
    logic                      w_last;
    logic [NIBBLES-1:0][3:0]   w_next_result;

    assign w_alu_a   = r_a[r_idx];
    assign w_alu_b   = r_b[r_idx];
    assign w_alu_cin = op_is_arith(r_op) ? r_carry : 1'b0;
    assign w_last    = (r_idx == IDX_W'(NIBBLES - 1));

    alu_4bit u_alu (
        .i_a      (w_alu_a),
        .i_b      (w_alu_b),
        .i_op     (r_op),
        .i_cin    (w_alu_cin),
        .o_result (w_alu_result),
        .o_cout   (w_alu_cout)
    );

    // Result with the current nibble merged in, so the zero flag can be registered
    // on the same edge that writes the final nibble.
    always_comb begin
        w_next_result        = r_result;
        w_next_result[r_idx] = w_alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_op        <= OP_ADD;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_cout      <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_a        <= in_a;
                        r_b        <= in_b;
                        r_op       <= in_op;
                        r_carry    <= 1'b0;
                        r_idx      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_result <= w_next_result;
                    r_carry  <= w_alu_cout;
                    if (w_last) begin
                        r_idx       <= '0;
                        r_cout      <= op_is_arith(r_op) ? w_alu_cout : 1'b0;
                        r_zero      <= (w_next_result == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_result  = r_result;
    assign out_cout    = r_cout;
    assign out_zero    = r_zero;
    assign o_dbg_state = r_state;

endmodule
